// File: rtl/funit_sched.sv
// funit_sched -- round-robin scheduler in front of a single 16-bit function unit.
//
// Grants one of NREQ requesters, latches its FS/A/B, drives them to the function
// unit and holds them for FU_LAT cycles. It then samples D and {V,C,N,Z} and
// returns them to the winner, tagged with the winner's index.
//
// Ports
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   req_valid[NREQ]       per-requester request pending
//   req_fs/req_a/req_b    packed per-requester operands (4/16/16 bits each)
//   req_ready[NREQ]       one-hot accept pulse; operands captured that cycle
//   rsp_valid/rsp_id      one-cycle result pulse and owning requester index
//   rsp_d/rsp_vcnz        captured result and {V,C,N,Z}
//   fu_fs/fu_a/fu_b       operands to the function unit
//   fu_d, fu_v..fu_z      result and flags from the function unit
//   busy                  high whenever the scheduler is not idle
module funit_sched #(
  parameter int NREQ   = 4,
  parameter int FU_LAT = 2,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_fs,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_d,
  output logic [3:0]           rsp_vcnz,
  output logic [3:0]           fu_fs,
  output logic [15:0]          fu_a,
  output logic [15:0]          fu_b,
  input  logic [15:0]          fu_d,
  input  logic                 fu_v,
  input  logic                 fu_c,
  input  logic                 fu_n,
  input  logic                 fu_z,
  output logic                 busy
);

  localparam int CW = $clog2(FU_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_r, state_s;
  logic [IDW-1:0]    rr_ptr_r, rr_ptr_s;
  logic [IDW-1:0]    win_r, win_s;
  logic [3:0]        op_fs_r, op_fs_s;
  logic [15:0]       op_a_r, op_a_s, op_b_r, op_b_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [NREQ-1:0]   ready_r, ready_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [IDW-1:0]    rsp_id_r, rsp_id_s;
  logic [15:0]       rsp_d_r, rsp_d_s;
  logic [3:0]        rsp_vcnz_r, rsp_vcnz_s;
  logic [3:0]        fu_fs_r, fu_fs_s;
  logic [15:0]       fu_a_r, fu_a_s, fu_b_r, fu_b_s;
  logic              busy_r, busy_s;

  logic [3:0]        fs_arr_s [NREQ];
  logic [15:0]       a_arr_s  [NREQ];
  logic [15:0]       b_arr_s  [NREQ];
  logic [IDW-1:0]    cand_s   [NREQ];
  logic              grant_found_s;
  logic [IDW-1:0]    grant_idx_s;

  // Unpack operands and search requesters starting at rr_ptr; first hit wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      fs_arr_s[i] = req_fs[4*i +: 4];
      a_arr_s[i]  = req_a[16*i +: 16];
      b_arr_s[i]  = req_b[16*i +: 16];
      cand_s[i]   = IDW'((int'(rr_ptr_r) + i) % NREQ);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found_s && req_valid[cand_s[k]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[k];
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Next-state and next-output logic; every output is a registered copy of these.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    win_s       = win_r;
    op_fs_s     = op_fs_r;
    op_a_s      = op_a_r;
    op_b_s      = op_b_r;
    cnt_s       = cnt_r;
    ready_s     = '0;
    rsp_valid_s = 1'b0;
    rsp_id_s    = rsp_id_r;
    rsp_d_s     = rsp_d_r;
    rsp_vcnz_s  = rsp_vcnz_r;
    fu_fs_s     = fu_fs_r;
    fu_a_s      = fu_a_r;
    fu_b_s      = fu_b_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          ready_s = NREQ'(1) << grant_idx_s;
          win_s   = grant_idx_s;
          op_fs_s = fs_arr_s[grant_idx_s];
          op_a_s  = a_arr_s[grant_idx_s];
          op_b_s  = b_arr_s[grant_idx_s];
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // fu_* only ever change here, so the unit sees stable operands.
        fu_fs_s = op_fs_r;
        fu_a_s  = op_a_r;
        fu_b_s  = op_b_r;
        cnt_s   = CW'(FU_LAT - 1);
        state_s = WAIT;
      end
      WAIT: begin
        if (cnt_r == '0) begin
          rsp_d_s    = fu_d;
          rsp_vcnz_s = {fu_v, fu_c, fu_n, fu_z};
          state_s    = RESP;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      RESP: begin
        rsp_valid_s = 1'b1;
        rsp_id_s    = win_r;
        rr_ptr_s    = (win_r == IDW'(NREQ - 1)) ? '0 : win_r + IDW'(1);
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; RESET aborts any operation without a response.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      win_r       <= '0;
      op_fs_r     <= 4'h0;
      op_a_r      <= 16'h0;
      op_b_r      <= 16'h0;
      cnt_r       <= '0;
      ready_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_d_r     <= 16'h0;
      rsp_vcnz_r  <= 4'h0;
      fu_fs_r     <= 4'h0;
      fu_a_r      <= 16'h0;
      fu_b_r      <= 16'h0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      win_r       <= win_s;
      op_fs_r     <= op_fs_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      cnt_r       <= cnt_s;
      ready_r     <= ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_id_r    <= rsp_id_s;
      rsp_d_r     <= rsp_d_s;
      rsp_vcnz_r  <= rsp_vcnz_s;
      fu_fs_r     <= fu_fs_s;
      fu_a_r      <= fu_a_s;
      fu_b_r      <= fu_b_s;
      busy_r      <= busy_s;
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_d     = rsp_d_r;
  assign rsp_vcnz  = rsp_vcnz_r;
  assign fu_fs     = fu_fs_r;
  assign fu_a      = fu_a_r;
  assign fu_b      = fu_b_r;
  assign busy      = busy_r;

endmodule
